// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared types and constants for the memory arbiter slice:
//   oplen_e      - access width encoding (byte, half, 24-bit, word)
//   arb_state_e  - arbiter FSM states
//   DEF_IMEM_CUTOFF / DEF_MMIO_ADDR - default address-map constants
// -----------------------------------------------------------------------------
package mem_pkg;

    typedef enum logic [1:0] {
        OP_BYTE = 2'b00,
        OP_HALF = 2'b01,
        OP_TRI  = 2'b10,
        OP_WORD = 2'b11
    } oplen_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } arb_state_e;

    localparam logic [31:0] DEF_IMEM_CUTOFF = 32'h0000_00FF;
    localparam logic [31:0] DEF_MMIO_ADDR   = 32'hFFFF_FFFF;

endpackage

// File: rtl/mem_sext.sv
// -----------------------------------------------------------------------------
// mem_sext
// Combinational result extension to 32 bits according to access width.
// Ports:
//   data_i     in  32  raw target result
//   unsigned_i in  1   1 = zero-extend, 0 = sign-extend
//   oplen_i    in  2   access width (oplen_e)
//   data_o     out 32  extended result
// -----------------------------------------------------------------------------
module mem_sext
    import mem_pkg::*;
(
    input  logic [31:0] data_i,
    input  logic        unsigned_i,
    input  oplen_e      oplen_i,
    output logic [31:0] data_o
);

    // Fill bits are the width's top bit for signed accesses, zero otherwise.
    always_comb begin
        data_o = data_i;
        case (oplen_i)
            OP_BYTE: data_o = {{24{~unsigned_i & data_i[7]}},  data_i[7:0]};
            OP_HALF: data_o = {{16{~unsigned_i & data_i[15]}}, data_i[15:0]};
            OP_TRI:  data_o = {{8{~unsigned_i & data_i[23]}},  data_i[23:0]};
            OP_WORD: data_o = data_i;
            default: data_o = data_i;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Round-robin arbiter granting one of NUM_PORTS requesters access to either the
// internal RAM (addr < IMEM_CUTOFF or addr == MMIO_ADDR) or the SDRAM (all
// other addresses, rebased by IMEM_CUTOFF). One transaction in flight at a time.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_enable/addr/wdata/we/oplen/unsigned   per-port request (held)
//   req_valid/result/err          per-port one-cycle completion pulse + data
//   iram_*                        internal RAM target handshake
//   ram_*                         SDRAM target handshake
// Optional build macro:
//   MEM_ARB_TIMEOUT_EN - watchdog in WAIT; after TIMEOUT_CYCLES with no target
//                        valid the transaction completes with result 0, err 1.
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int          NUM_PORTS      = 2,
    parameter logic [31:0] IMEM_CUTOFF    = mem_pkg::DEF_IMEM_CUTOFF,
    parameter logic [31:0] MMIO_ADDR      = mem_pkg::DEF_MMIO_ADDR,
    parameter int          RAM_AW         = 25,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_PORTS-1:0]        req_enable,
    output logic [NUM_PORTS-1:0]        req_valid,
    input  logic [NUM_PORTS-1:0][31:0]  req_addr,
    input  logic [NUM_PORTS-1:0][31:0]  req_wdata,
    input  logic [NUM_PORTS-1:0]        req_we,
    input  logic [NUM_PORTS-1:0][1:0]   req_oplen,
    input  logic [NUM_PORTS-1:0]        req_unsigned,
    output logic [NUM_PORTS-1:0][31:0]  req_result,
    output logic [NUM_PORTS-1:0]        req_err,
    output logic                        iram_enable,
    input  logic                        iram_valid,
    output logic [31:0]                 iram_addr,
    output logic [1:0]                  iram_oplen,
    output logic                        iram_we,
    output logic [31:0]                 iram_wdata,
    input  logic [31:0]                 iram_result,
    output logic                        ram_enable,
    input  logic                        ram_valid,
    output logic [RAM_AW-1:0]           ram_addr,
    output logic [1:0]                  ram_oplen,
    output logic                        ram_we,
    output logic [31:0]                 ram_wdata,
    input  logic [31:0]                 ram_result
);
    import mem_pkg::*;

    localparam int            PW   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [PW:0]   NP_W = (PW+1)'(NUM_PORTS);

    arb_state_e      state_q;
    logic [PW-1:0]   rr_ptr_q;
    logic [PW-1:0]   port_q;
    oplen_e          oplen_q;
    logic            unsigned_q;
    logic            sel_iram_q;

    logic            grant_found_s;
    logic [PW-1:0]   grant_idx_s;
    logic [PW:0]     cand_s;
    logic [31:0]     gaddr_s;
    logic [31:0]     ram_off_s;
    logic            is_iram_s;
    logic            tgt_valid_s;
    logic [31:0]     tgt_result_s;
    logic [31:0]     ext_result_s;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int         CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0]         wd_cnt_q;
    logic [NUM_PORTS-1:0]  req_err_q;
    logic                  wd_expired_s;
    // Counter starts at 0 on the grant edge, so expiry lands TIMEOUT_CYCLES after enable rises.
    assign wd_expired_s = (wd_cnt_q == CW'(TIMEOUT_CYCLES - 1));
    assign req_err      = req_err_q;
`else
    assign req_err      = '0;
`endif

    // Round-robin search: first enabled port at or after rr_ptr_q, wrapping.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        cand_s        = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            cand_s = {1'b0, rr_ptr_q} + (PW+1)'(i);
            cand_s = (cand_s >= NP_W) ? (cand_s - NP_W) : cand_s;
            if (!grant_found_s && req_enable[cand_s[PW-1:0]]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = cand_s[PW-1:0];
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // Address decode of the candidate grant and selection of the active target.
    always_comb begin
        gaddr_s      = req_addr[grant_idx_s];
        ram_off_s    = gaddr_s - IMEM_CUTOFF;
        is_iram_s    = (gaddr_s < IMEM_CUTOFF) || (gaddr_s == MMIO_ADDR);
        tgt_valid_s  = sel_iram_q ? iram_valid  : ram_valid;
        tgt_result_s = sel_iram_q ? iram_result : ram_result;
    end

    mem_sext u_sext (
        .data_i     (tgt_result_s),
        .unsigned_i (unsigned_q),
        .oplen_i    (oplen_q),
        .data_o     (ext_result_s)
    );

    // Arbiter FSM with all target and requester outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            port_q      <= '0;
            oplen_q     <= OP_BYTE;
            unsigned_q  <= 1'b0;
            sel_iram_q  <= 1'b0;
            req_valid   <= '0;
            req_result  <= '0;
            iram_enable <= 1'b0;
            iram_addr   <= '0;
            iram_oplen  <= '0;
            iram_we     <= 1'b0;
            iram_wdata  <= '0;
            ram_enable  <= 1'b0;
            ram_addr    <= '0;
            ram_oplen   <= '0;
            ram_we      <= 1'b0;
            ram_wdata   <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            wd_cnt_q    <= '0;
            req_err_q   <= '0;
`endif
        end else begin
            req_valid <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            req_err_q <= '0;
`endif
            case (state_q)
                IDLE: begin
                    if (grant_found_s) begin
                        port_q      <= grant_idx_s;
                        rr_ptr_q    <= (grant_idx_s == PW'(NUM_PORTS - 1)) ? '0
                                                                           : grant_idx_s + PW'(1);
                        oplen_q     <= oplen_e'(req_oplen[grant_idx_s]);
                        unsigned_q  <= req_unsigned[grant_idx_s];
                        sel_iram_q  <= is_iram_s;
                        // Both targets see the latched request; only the enable differs.
                        iram_addr   <= gaddr_s;
                        iram_oplen  <= req_oplen[grant_idx_s];
                        iram_we     <= req_we[grant_idx_s];
                        iram_wdata  <= req_wdata[grant_idx_s];
                        ram_addr    <= ram_off_s[RAM_AW-1:0];
                        ram_oplen   <= req_oplen[grant_idx_s];
                        ram_we      <= req_we[grant_idx_s];
                        ram_wdata   <= req_wdata[grant_idx_s];
                        iram_enable <= is_iram_s;
                        ram_enable  <= ~is_iram_s;
`ifdef MEM_ARB_TIMEOUT_EN
                        wd_cnt_q    <= '0;
`endif
                        state_q     <= WAIT;
                    end else begin
                        state_q     <= IDLE;
                    end
                end
                WAIT: begin
                    if (tgt_valid_s) begin
                        iram_enable        <= 1'b0;
                        ram_enable         <= 1'b0;
                        req_valid[port_q]  <= 1'b1;
                        req_result[port_q] <= ext_result_s;
                        state_q            <= RESP;
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    else if (wd_expired_s) begin
                        iram_enable        <= 1'b0;
                        ram_enable         <= 1'b0;
                        req_valid[port_q]  <= 1'b1;
                        req_result[port_q] <= '0;
                        req_err_q[port_q]  <= 1'b1;
                        state_q            <= RESP;
                    end else begin
                        wd_cnt_q           <= wd_cnt_q + CW'(1);
                        state_q            <= WAIT;
                    end
`else
                    else begin
                        state_q            <= WAIT;
                    end
`endif
                end
                // The pulse is visible during RESP; arbitration resumes next cycle.
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int NP     = 2;
    localparam int RAM_AW = 25;
`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TO_CYC = 16;
`else
    localparam int TO_CYC = 1024;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NP-1:0]        req_enable;
    logic [NP-1:0]        req_valid;
    logic [NP-1:0][31:0]  req_addr;
    logic [NP-1:0][31:0]  req_wdata;
    logic [NP-1:0]        req_we;
    logic [NP-1:0][1:0]   req_oplen;
    logic [NP-1:0]        req_unsigned;
    logic [NP-1:0][31:0]  req_result;
    logic [NP-1:0]        req_err;
    logic                 iram_enable, iram_valid, iram_we;
    logic [31:0]          iram_addr, iram_wdata, iram_result;
    logic [1:0]           iram_oplen;
    logic                 ram_enable, ram_valid, ram_we;
    logic [RAM_AW-1:0]    ram_addr;
    logic [31:0]          ram_wdata, ram_result;
    logic [1:0]           ram_oplen;

    always #5 clk = ~clk;

    mem_arbiter #(
        .NUM_PORTS(NP), .IMEM_CUTOFF(32'h0000_00FF), .MMIO_ADDR(32'hFFFF_FFFF),
        .RAM_AW(RAM_AW), .TIMEOUT_CYCLES(TO_CYC)
    ) dut (
        .clk(clk), .rst(rst),
        .req_enable(req_enable), .req_valid(req_valid), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_we(req_we), .req_oplen(req_oplen),
        .req_unsigned(req_unsigned), .req_result(req_result), .req_err(req_err),
        .iram_enable(iram_enable), .iram_valid(iram_valid), .iram_addr(iram_addr),
        .iram_oplen(iram_oplen), .iram_we(iram_we), .iram_wdata(iram_wdata),
        .iram_result(iram_result),
        .ram_enable(ram_enable), .ram_valid(ram_valid), .ram_addr(ram_addr),
        .ram_oplen(ram_oplen), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .ram_result(ram_result)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int p, input logic [31:0] a, input logic [31:0] wd,
                         input logic we, input logic [1:0] ol, input logic uns);
        req_addr[p]     = a;
        req_wdata[p]    = wd;
        req_we[p]       = we;
        req_oplen[p]    = ol;
        req_unsigned[p] = uns;
        req_enable[p]   = 1'b1;
    endtask

    int order[8];
    int n_grants;
    int overlaps;
    int onehot_bad;

    initial begin
        rst          = 1'b1;
        req_enable   = '0;
        req_addr     = '0;
        req_wdata    = '0;
        req_we       = '0;
        req_oplen    = '0;
        req_unsigned = '0;
        iram_valid   = 1'b0;
        iram_result  = '0;
        ram_valid    = 1'b0;
        ram_result   = '0;
        step();
        step();

        // Reset state
        check_value("rst_req_valid", 32'(req_valid), 32'h0);
        check_value("rst_req_result0", req_result[0], 32'h0);
        check_value("rst_req_result1", req_result[1], 32'h0);
        check_value("rst_enables", {30'h0, iram_enable, ram_enable}, 32'h0);
        check_value("rst_iram_addr", iram_addr, 32'h0);
        check_value("rst_ram_addr", 32'(ram_addr), 32'h0);
        check_value("rst_req_err", 32'(req_err), 32'h0);
        rst = 1'b0;

        // Port0 signed byte read from internal RAM, data arrives 2 cycles after enable
        issue(0, 32'h0000_0010, 32'h0, 1'b0, 2'b00, 1'b0);
        step();
        check_value("b_iram_en", 32'(iram_enable), 32'h1);
        check_value("b_ram_en", 32'(ram_enable), 32'h0);
        check_value("b_iram_addr", iram_addr, 32'h0000_0010);
        req_enable[0] = 1'b0;            // dropping the request must not abort
        ram_valid     = 1'b1;            // unselected target valid is ignored
        ram_result    = 32'h5555_5555;
        step();
        check_value("b_wait_no_valid", 32'(req_valid), 32'h0);
        check_value("b_wait_iram_en", 32'(iram_enable), 32'h1);
        ram_valid   = 1'b0;
        iram_valid  = 1'b1;
        iram_result = 32'h0000_00F3;
        step();
        check_value("b_req_valid", 32'(req_valid), 32'h1);
        check_value("b_result", req_result[0], 32'hFFFF_FFF3);
        check_value("b_iram_drop", 32'(iram_enable), 32'h0);
        iram_valid = 1'b0;
        step();
        check_value("b_pulse_one", 32'(req_valid), 32'h0);

        // Port1 word write to SDRAM
        issue(1, 32'h0000_1000, 32'hDEAD_BEEF, 1'b1, 2'b11, 1'b0);
        step();
        check_value("w_ram_en", 32'(ram_enable), 32'h1);
        check_value("w_iram_en", 32'(iram_enable), 32'h0);
        check_value("w_ram_addr", 32'(ram_addr), 32'h0000_0F01);
        check_value("w_ram_we", 32'(ram_we), 32'h1);
        check_value("w_ram_wdata", ram_wdata, 32'hDEAD_BEEF);
        req_enable[1] = 1'b0;
        ram_valid     = 1'b1;
        ram_result    = 32'h0000_1234;
        step();
        check_value("w_req_valid", 32'(req_valid), 32'h2);
        check_value("w_result", req_result[1], 32'h0000_1234);
        check_value("w_hold_p0", req_result[0], 32'hFFFF_FFF3);
        ram_valid = 1'b0;
        step();

        // MMIO address, unsigned half read
        issue(0, 32'hFFFF_FFFF, 32'h0, 1'b0, 2'b01, 1'b1);
        step();
        check_value("m_iram_en", 32'(iram_enable), 32'h1);
        check_value("m_ram_en", 32'(ram_enable), 32'h0);
        check_value("m_iram_oplen", 32'(iram_oplen), 32'h1);
        req_enable[0] = 1'b0;
        iram_valid    = 1'b1;
        iram_result   = 32'h1234_8001;
        step();
        check_value("m_req_valid", 32'(req_valid), 32'h1);
        check_value("m_result", req_result[0], 32'h0000_8001);
        iram_valid = 1'b0;
        step();

        // Port1 signed 24-bit read just below the cutoff
        issue(1, 32'h0000_00FE, 32'h0, 1'b0, 2'b10, 1'b0);
        step();
        check_value("t_iram_en", 32'(iram_enable), 32'h1);
        req_enable[1] = 1'b0;
        iram_valid    = 1'b1;
        iram_result   = 32'hAB80_0000;
        step();
        check_value("t_result", req_result[1], 32'hFF80_0000);
        iram_valid = 1'b0;
        step();

        // Port0 word read exactly at the cutoff -> SDRAM offset 0
        issue(0, 32'h0000_00FF, 32'h0, 1'b0, 2'b11, 1'b0);
        step();
        check_value("c_ram_en", 32'(ram_enable), 32'h1);
        check_value("c_ram_addr", 32'(ram_addr), 32'h0);
        req_enable[0] = 1'b0;
        ram_valid     = 1'b1;
        ram_result    = 32'h8000_0000;
        step();
        check_value("c_result", req_result[0], 32'h8000_0000);
        ram_valid = 1'b0;
        step();

        // Both ports held from reset: grants alternate, targets never overlap
        rst = 1'b1;
        step();
        rst = 1'b0;
        issue(0, 32'h0000_0040, 32'h0, 1'b0, 2'b11, 1'b0);
        issue(1, 32'h0000_2000, 32'h0, 1'b0, 2'b11, 1'b0);
        iram_result = 32'h0000_0011;
        ram_result  = 32'h0000_0022;
        n_grants    = 0;
        overlaps    = 0;
        onehot_bad  = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (iram_enable && ram_enable) overlaps++;
            if (req_valid == 2'b11) onehot_bad++;
            if (req_valid != 2'b00 && n_grants < 8) begin
                order[n_grants] = req_valid[1] ? 1 : 0;
                n_grants++;
            end
            iram_valid = iram_enable;
            ram_valid  = ram_enable;
        end
        iram_valid = 1'b0;
        ram_valid  = 1'b0;
        check_value("rr_overlap", 32'(overlaps), 32'h0);
        check_value("rr_onehot", 32'(onehot_bad), 32'h0);
        check_value("rr_min_grants", 32'(n_grants >= 4), 32'h1);
        for (int k = 0; k < 4; k++) begin
            check_value($sformatf("rr_order%0d", k), 32'(order[k]), 32'(k % 2));
        end
        check_value("rr_res0", req_result[0], 32'h0000_0011);
        check_value("rr_res1", req_result[1], 32'h0000_0022);

        // Reset while WAIT discards the transaction
        req_enable = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        issue(0, 32'h0000_0010, 32'h0, 1'b0, 2'b11, 1'b0);
        step();
        check_value("r_iram_en", 32'(iram_enable), 32'h1);
        req_enable  = '0;
        rst         = 1'b1;
        iram_valid  = 1'b1;
        step();
        check_value("r_enables", {30'h0, iram_enable, ram_enable}, 32'h0);
        check_value("r_no_valid", 32'(req_valid), 32'h0);
        rst        = 1'b0;
        iram_valid = 1'b0;
        step();
        check_value("r_no_valid2", 32'(req_valid), 32'h0);

`ifdef MEM_ARB_TIMEOUT_EN
        // Silent target: watchdog completes with err after TIMEOUT_CYCLES
        issue(1, 32'h0000_3000, 32'h0, 1'b0, 2'b11, 1'b0);
        step();
        check_value("to_ram_en", 32'(ram_enable), 32'h1);
        req_enable = '0;
        for (int c = 1; c < TO_CYC; c++) begin
            step();
            check_value($sformatf("to_quiet%0d", c), 32'(req_valid), 32'h0);
        end
        step();
        check_value("to_valid", 32'(req_valid), 32'h2);
        check_value("to_err", 32'(req_err), 32'h2);
        check_value("to_result", req_result[1], 32'h0);
        check_value("to_ram_drop", 32'(ram_enable), 32'h0);
        step();
        check_value("to_err_clear", 32'(req_err), 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
